// File: rtl/write_out_pkg.sv
// Shared constants and width helpers for the write-out path.
// Default geometry and the row-range rule live here.
package write_out_pkg;

    localparam int DEF_ARRAY_SIZE = 8;
    localparam int DEF_OUTPUT_DATA_WIDTH = 16;
    localparam int ROW_SPAN = 2 * DEF_ARRAY_SIZE;
    localparam int G_WIDTH = 8;

    typedef logic [G_WIDTH-1:0] grow_t;

    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int addr_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int drop_limit(input int array_size);
        return 2 * array_size;
    endfunction

endpackage

// File: rtl/write_out_fifo.sv
// Parametrised synchronous FIFO with full/empty flags and occupancy.
// Read data is the current head, valid whenever empty is low.
module write_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case (1'b1)
                push_ok && !pop_ok: count <= count + (PTR_W+1)'(1);
                pop_ok && !push_ok: count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/write_out_router.sv
// Routes quantized rows to SRAM banks through a small FIFO,
// issuing one registered write per cycle to a non-busy bank.
module write_out_router
    import write_out_pkg::*;
#(
    parameter int ARRAY_SIZE        = DEF_ARRAY_SIZE,
    parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
    parameter int NUM_BANKS         = 3,
    parameter int ROWS_PER_BANK     = 8,
    parameter int ADDR_WIDTH        = 6,
    parameter int FIFO_DEPTH        = 4,
    parameter int FRAME_ROWS        = 24
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [1:0]                              data_set,
    input  logic [5:0]                              matrix_index,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
    input  logic                                    reverse_lanes,
    input  logic [NUM_BANKS-1:0]                    bank_busy,
    output logic [NUM_BANKS-1:0]                    sram_wen_n,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata,
    output logic [ADDR_WIDTH-1:0]                   sram_waddr,
    output logic                                    drop_err,
    output logic                                    frame_done
);

    localparam int W         = OUTPUT_DATA_WIDTH;
    localparam int DATA_W    = ARRAY_SIZE * W;
    localparam int BANK_W    = bank_width(NUM_BANKS);
    localparam int ENTRY_W   = BANK_W + ADDR_WIDTH + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_ROWS + 1);
    localparam int ROW_LIMIT = drop_limit(ARRAY_SIZE);

    grow_t               g;
    grow_t               bank_full;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic                out_of_range;
    logic [DATA_W-1:0]   lanes;
    logic [ENTRY_W-1:0]  entry_in;
    logic [ENTRY_W-1:0]  head;
    logic [BANK_W-1:0]   head_bank;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [NUM_BANKS-1:0] wen_sel;
    logic                accept;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                head_busy;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic [CNT_W-1:0]    wr_cnt;

    always_comb begin
        g = G_WIDTH'(data_set) * G_WIDTH'(ROW_LIMIT)
          + G_WIDTH'(matrix_index);
        bank_full = g / G_WIDTH'(ROWS_PER_BANK);
        row_addr  = ADDR_WIDTH'(g % G_WIDTH'(ROWS_PER_BANK));
        out_of_range = (int'(matrix_index) >= ROW_LIMIT)
                    || (int'(bank_full) >= NUM_BANKS);
    end

    always_comb begin
        lanes = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lanes[i*W +: W] = reverse_lanes
                ? in_data[(ARRAY_SIZE-1-i)*W +: W]
                : in_data[i*W +: W];
        end
    end

    assign entry_in = {BANK_W'(bank_full), row_addr, lanes};
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !out_of_range;

    assign head_bank = head[ENTRY_W-1 -: BANK_W];
    assign head_addr = head[DATA_W +: ADDR_WIDTH];
    assign head_data = head[DATA_W-1:0];

    always_comb begin
        wen_sel = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wen_sel[b] = (head_bank != BANK_W'(b));
        end
    end

    // A busy head bank stalls the whole queue to keep rows in order.
    assign head_busy = |(bank_busy & ~wen_sel);
    assign pop       = !empty && !head_busy;

    write_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srstn (srstn),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (unused_count)
    );

    always_ff @(posedge clk) begin
        if (!srstn) begin
            sram_wen_n <= '1;
            sram_wdata <= '0;
            sram_waddr <= '0;
            drop_err   <= 1'b0;
            frame_done <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            sram_wen_n <= '1;
            sram_wdata <= '0;
            sram_waddr <= '0;
            drop_err   <= accept && out_of_range;
            frame_done <= 1'b0;
            if (pop) begin
                sram_wen_n <= wen_sel;
                sram_wdata <= head_data;
                sram_waddr <= head_addr;
                if (wr_cnt == CNT_W'(FRAME_ROWS - 1)) begin
                    wr_cnt     <= '0;
                    frame_done <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_write_out_router.sv
// Directed bench for write_out_router with an in-order write scoreboard.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_write_out_router;

    logic         clk = 1'b0;
    logic         srstn;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   data_set;
    logic [5:0]   matrix_index;
    logic [127:0] in_data;
    logic         reverse_lanes;
    logic [2:0]   bank_busy;
    logic [2:0]   sram_wen_n;
    logic [127:0] sram_wdata;
    logic [5:0]   sram_waddr;
    logic         drop_err;
    logic         frame_done;

    typedef struct {
        logic [1:0]   bank;
        logic [5:0]   addr;
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           lag_q[$];
    int           fd_q[$];
    logic [127:0] wd_q[$];
    int tests = 0;
    int fails = 0;
    int ncyc = 0;
    int wr_total = 0;
    int drops = 0;
    int multi_low = 0;
    int stray = 0;

    always #5 clk = ~clk;

    write_out_router dut (
        .clk           (clk),
        .srstn         (srstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_set      (data_set),
        .matrix_index  (matrix_index),
        .in_data       (in_data),
        .reverse_lanes (reverse_lanes),
        .bank_busy     (bank_busy),
        .sram_wen_n    (sram_wen_n),
        .sram_wdata    (sram_wdata),
        .sram_waddr    (sram_waddr),
        .drop_err      (drop_err),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] row_data(input int tag);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = {8'(tag), 8'(i)};
        return d;
    endfunction

    function automatic logic [127:0] revl(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = d[(7-i)*16 +: 16];
        return r;
    endfunction

    // Write monitor and scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] ob;
        ncyc++;
        if (drop_err === 1'b1) drops++;
        if (!$isunknown(sram_wen_n) && sram_wen_n != 3'b111) begin
            if ($countones(~sram_wen_n) != 1) multi_low++;
            ob = !sram_wen_n[0] ? 2'd0 : (!sram_wen_n[1] ? 2'd1 : 2'd2);
            wr_total++;
            wd_q.push_back(sram_wdata);
            if (frame_done === 1'b1) fd_q.push_back(wr_total);
            if (exp_q.size() == 0) begin
                stray++;
            end else begin
                e = exp_q.pop_front();
                chk("write", {ob, sram_waddr, sram_wdata},
                    {e.bank, e.addr, e.data});
                lag_q.push_back(ncyc - e.acc);
            end
        end else if (frame_done === 1'b1) begin
            stray++;
        end
    end

    task automatic push_row(input logic [1:0] s, input logic [5:0] idx,
                            input logic [127:0] d, input logic rev);
        int   g;
        bit   ok;
        exp_t e;
        g = int'(s) * 16 + int'(idx);
        data_set = s;
        matrix_index = idx;
        in_data = d;
        reverse_lanes = rev;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            ok = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (ok) begin
                if (idx < 16 && g / 8 < 3) begin
                    e.bank = 2'(g / 8);
                    e.addr = 6'(g % 8);
                    e.data = rev ? revl(d) : d;
                    e.acc  = ncyc;
                    exp_q.push_back(e);
                end
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        tests++;
        fails++;
        $error("FAIL accept_timeout: got no accept expected accept");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int l0;
        int bad;
        logic [127:0] d1;
        srstn = 1'b0;
        in_valid = 1'b0;
        data_set = '0;
        matrix_index = '0;
        in_data = '0;
        reverse_lanes = 1'b0;
        bank_busy = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen_n", sram_wen_n, 3'b111);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_waddr", sram_waddr, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_frame", frame_done, 0);
        srstn = 1'b1;
        idle(1);
        chk("rst_ready", in_ready, 1);

        // Full frame, back-to-back
        for (int g = 0; g < 24; g++)
            push_row(2'(g / 16), 6'(g % 16), row_data(g), 1'b0);
        idle(4);
        chk("frame_writes", wr_total, 24);
        chk("frame_lag0", lag_q.size() > 0 ? lag_q[0] : -1, 2);
        bad = 0;
        foreach (lag_q[i]) if (lag_q[i] != 2) bad++;
        chk("frame_b2b", bad, 0);
        chk("frame_done_n", fd_q.size(), 1);
        chk("frame_done_at", fd_q.size() > 0 ? fd_q[0] : -1, 24);

        // Out-of-range rows
        w0 = wr_total;
        push_row(2'd1, 6'd8, row_data(90), 1'b0);
        chk("drop_pulse", drop_err, 1);
        idle(1);
        chk("drop_clear", drop_err, 0);
        push_row(2'd0, 6'd16, row_data(91), 1'b0);
        idle(3);
        chk("drop_count", drops, 2);
        chk("drop_nowrite", wr_total - w0, 0);

        // Bank 1 busy with six queued rows
        w0 = wr_total;
        bank_busy = 3'b010;
        for (int k = 0; k < 4; k++)
            push_row(2'd0, 6'(8 + k), row_data(100 + k), 1'b0);
        chk("stall_full", in_ready, 0);
        data_set = 2'd0;
        matrix_index = 6'd12;
        in_data = row_data(104);
        in_valid = 1'b1;
        idle(2);
        chk("stall_ready", in_ready, 0);
        chk("stall_nowrite", wr_total - w0, 0);
        bank_busy = 3'b000;
        push_row(2'd0, 6'd12, row_data(104), 1'b0);
        push_row(2'd0, 6'd13, row_data(105), 1'b0);
        idle(8);
        chk("stall_writes", wr_total - w0, 6);
        chk("stall_drained", exp_q.size(), 0);

        // Lane reversal
        for (int i = 0; i < 8; i++) d1[i*16 +: 16] = 16'(i + 1);
        push_row(2'd0, 6'd0, d1, 1'b1);
        push_row(2'd0, 6'd1, d1, 1'b0);
        idle(4);
        l0 = wd_q.size();
        chk("rev_lane0", wd_q[l0-2][15:0], 16'd8);
        chk("rev_lane7", wd_q[l0-2][127:112], 16'd1);
        chk("fwd_lane0", wd_q[l0-1][15:0], 16'd1);
        chk("fwd_lane7", wd_q[l0-1][127:112], 16'd8);

        // Reset with three buffered rows
        bank_busy = 3'b111;
        push_row(2'd0, 6'd2, row_data(120), 1'b0);
        push_row(2'd0, 6'd3, row_data(121), 1'b0);
        push_row(2'd0, 6'd4, row_data(122), 1'b0);
        w0 = wr_total;
        srstn = 1'b0;
        idle(1);
        exp_q.delete();
        chk("mid_rst_wen_n", sram_wen_n, 3'b111);
        chk("mid_rst_wdata", sram_wdata, 0);
        chk("mid_rst_waddr", sram_waddr, 0);
        chk("mid_rst_frame", frame_done, 0);
        srstn = 1'b1;
        bank_busy = 3'b000;
        chk("mid_rst_ready", in_ready, 1);
        idle(5);
        chk("mid_rst_flushed", wr_total - w0, 0);
        l0 = lag_q.size();
        for (int g = 0; g < 24; g++)
            push_row(2'(g / 16), 6'(g % 16), row_data(50 + g), 1'b0);
        idle(4);
        chk("post_rst_lag", lag_q.size() > l0 ? lag_q[l0] : -1, 2);
        chk("post_rst_frame_n", fd_q.size(), 2);
        chk("post_rst_frame_at", fd_q.size() > 1 ? fd_q[1] : -1, w0 + 24);

        // Push and pop together at constant occupancy
        l0 = lag_q.size();
        bank_busy = 3'b001;
        push_row(2'd0, 6'd0, row_data(150), 1'b0);
        push_row(2'd0, 6'd1, row_data(151), 1'b0);
        bank_busy = 3'b000;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready !== 1'b1) bad++;
            push_row(2'(((2 + k) % 24) / 16), 6'(((2 + k) % 24) % 16),
                     row_data(160 + k), 1'b0);
        end
        chk("pp_ready", bad, 0);
        idle(6);
        chk("pp_writes", lag_q.size() - l0, 22);
        bad = 0;
        for (int i = l0 + 2; i < lag_q.size(); i++)
            if (lag_q[i] != 3) bad++;
        chk("pp_lag", bad, 0);

        chk("one_low", multi_low, 0);
        chk("stray", stray, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_out_router.md
WRITE_OUT_ROUTER -- requirements
Module: write_out_router

Interface
REQ-001 SHALL have parameters: ARRAY_SIZE, default 8, lanes per row; OUTPUT_DATA_WIDTH, default 16, bits per lane; NUM_BANKS, default 3, SRAM banks; ROWS_PER_BANK, default 8, rows per bank; ADDR_WIDTH, default 6, SRAM address bits; FIFO_DEPTH, default 4, buffered rows (power of 2, >=2); FRAME_ROWS, default 24, writes per frame.
REQ-002 SHALL have ports: clk in 1, the single clock; srstn in 1, synchronous active-low reset.
REQ-003 in_valid in 1, row offered; in_ready out 1, row accepted when in_valid & in_ready at a rising edge.
REQ-004 data_set in 2, row set; matrix_index in 6, row index within set; in_data in ARRAY_SIZE*OUTPUT_DATA_WIDTH, quantized row, lane 0 in LSBs.
REQ-005 reverse_lanes in 1, sampled with the row: store lane i at lane ARRAY_SIZE-1-i.
REQ-006 bank_busy in NUM_BANKS, bank b cannot accept a write this cycle.
REQ-007 sram_wen_n out NUM_BANKS, active-low write enable, at most one bit low per cycle; sram_wdata out ARRAY_SIZE*OUTPUT_DATA_WIDTH; sram_waddr out ADDR_WIDTH; both shared by all banks.
REQ-008 drop_err out 1, one-cycle pulse, out-of-range row discarded; frame_done out 1, one-cycle pulse, frame written.

Function
REQ-009 Global row g = data_set*2*ARRAY_SIZE + matrix_index; bank = g / ROWS_PER_BANK; addr = g mod ROWS_PER_BANK.
REQ-010 Row is out of range if matrix_index >= 2*ARRAY_SIZE or bank >= NUM_BANKS; it SHALL be accepted, not buffered, and drop_err SHALL pulse in the cycle after acceptance.
REQ-011 In-range rows SHALL be pushed into the FIFO with their bank, addr and lane-ordered data resolved at push time.
REQ-012 in_ready = FIFO not full; no push when full, even if a pop occurs in the same cycle.
REQ-013 Head is popped at an edge when the FIFO is non-empty and bank_busy[head bank] = 0. At that edge outputs load: wen_n[bank]=0, wdata and waddr from the head.
REQ-014 Every other edge SHALL load wen_n all 1, wdata 0, waddr 0. This covers an empty FIFO or a busy bank; the head is held and stays in order.
REQ-015 Minimum latency: a row accepted at edge E into an empty FIFO SHALL drive its write in the cycle after edge E+1. Sustained throughput is one row per cycle.
REQ-016 Simultaneous push and pop SHALL be allowed when not full; occupancy is unchanged.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-018 Write counter SHALL increment on each issued write. On reaching FRAME_ROWS it SHALL clear to 0 and pulse frame_done in the same cycle as that write.
REQ-019 Dropped rows SHALL NOT count toward FRAME_ROWS.
REQ-020 Address arithmetic: g computed at 8 bits, then truncated to ADDR_WIDTH for addr.

Reset
REQ-021 While srstn=0 at an edge: sram_wen_n all 1, sram_wdata 0, sram_waddr 0, drop_err 0, frame_done 0. FIFO is emptied, write counter is 0, and in_ready is 1 from the following cycle.
REQ-022 Reset mid-operation SHALL discard all buffered rows; no write from before reset may issue after it.

Structure
REQ-023 Shared package write_out_pkg SHALL hold bank/addr width helper constants, the default ARRAY_SIZE/OUTPUT_DATA_WIDTH, and the drop-range rule constant 2*ARRAY_SIZE.
REQ-024 Buffer SHALL be the sub-module write_out_fifo, a parametrised synchronous FIFO with full/empty and a count output. Routing, lane reversal and the output register stay in write_out_router.

Verification
REQ-025 After reset, stream set0 idx0..15 and set1 idx0..7, one per cycle, with no busy -> 24 writes: bank0 addr0-7, bank1 addr0-7, bank2 addr0-7, in order, back-to-back. frame_done pulses with the 24th write.
REQ-026 Row set1 idx8 -> no write; drop_err pulses once; write counter unchanged.
REQ-027 bank_busy[1]=1 for 6 cycles with 6 rows queued for bank1 -> in_ready low after 4 buffered rows. No wen_n low during the stall. After release, 6 writes follow in order.
REQ-028 reverse_lanes=1 with lane i = i+1 -> sram_wdata lane 0 = 8, lane 7 = 1; reverse_lanes=0 -> lanes unchanged.
REQ-029 srstn low for one edge with 3 rows buffered -> all outputs at reset values, no buffered write ever issues, counter 0, next accepted row written with 2-edge latency.
REQ-030 Push and pop in the same cycle for 20 cycles at depth 4 -> occupancy constant, no loss or duplicate across pointer wrap.
